// File: rtl/axis_trigger_capture.sv
// Pre/post-trigger window capture into a circular buffer, replayed oldest-first on AXI-Stream.
// Replay path: 1-cycle RAM read -> output register with a one-entry skid register.
module axis_trigger_capture #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int ADDR_WIDTH       = 10
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        arm,
  input  logic [ADDR_WIDTH-1:0]       pre_data,
  input  logic [ADDR_WIDTH:0]         tot_data,
  input  logic                        trg_flag,
  output logic [2:0]                  sts_state,
  output logic [ADDR_WIDTH-1:0]       sts_trg_addr,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   ONE_W   = 1;
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    ARMED   = 3'd2,
    POST    = 3'd3,
    READOUT = 3'd4
  } state_t;

  state_t state, state_next;

  logic [AXIS_TDATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr, trg_addr, pre;
  logic [ADDR_WIDTH:0]   tot, cnt, rd_cnt, post_len;
  logic [ADDR_WIDTH:0]   tot_clamp, tot_m1;
  logic [ADDR_WIDTH-1:0] pre_clamp;

  logic accept, arm_ok, fill_done, trig_hit, post_done, out_pop, last_pop;
  logic wr_en, rd_en;
  logic [1:0] occ;

  logic [AXIS_TDATA_WIDTH-1:0] rd_q, skid_data, out_data;
  logic rd_q_valid, rd_q_last, skid_valid, skid_last, out_valid, out_last;

  assign s_axis_tready = 1'b1;
  assign accept        = s_axis_tvalid;
  assign tot_clamp     = (tot_data > DEPTH_W) ? DEPTH_W : tot_data;
  assign tot_m1        = tot_clamp - ONE_W;
  assign pre_clamp     = ({1'b0, pre_data} >= tot_clamp) ? tot_m1[ADDR_WIDTH-1:0] : pre_data;
  assign arm_ok        = arm && (tot_data != '0);
  assign post_len      = tot - {1'b0, pre};
  assign fill_done     = (cnt == {1'b0, pre}) || (accept && ((cnt + ONE_W) == {1'b0, pre}));
  assign trig_hit      = accept && trg_flag;
  assign post_done     = accept && ((cnt + ONE_W) == post_len);
  assign out_pop       = out_valid && m_axis_tready;
  assign last_pop      = out_pop && out_last;
  // Items that will occupy out/skid after this edge; a new read lands one cycle later.
  assign occ           = 2'(out_valid) + 2'(skid_valid) + 2'(rd_q_valid) - 2'(out_pop);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arm_ok) state_next = FILL;
      FILL:    if (fill_done) state_next = ARMED;
      ARMED:   if (trig_hit) state_next = (post_len == ONE_W) ? READOUT : POST;
      POST:    if (post_done) state_next = READOUT;
      READOUT: if (last_pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wr_en = 1'b0;
    rd_en = 1'b0;
    case (state)
      FILL, ARMED, POST: wr_en = accept;
      READOUT:           rd_en = (rd_cnt != tot) && (occ < 2'd2);
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      trg_addr <= '0;
      pre      <= '0;
      tot      <= '0;
      cnt      <= '0;
      rd_cnt   <= '0;
    end else begin
      if (wr_en) wr_addr <= wr_addr + ONE_A;
      case (state)
        IDLE: if (arm_ok) begin
          pre <= pre_clamp;
          tot <= tot_clamp;
          cnt <= '0;
        end
        FILL: if (accept) cnt <= cnt + ONE_W;
        ARMED: if (trig_hit) begin
          trg_addr <= wr_addr;
          rd_addr  <= wr_addr - pre;
          cnt      <= ONE_W;
          rd_cnt   <= '0;
        end
        POST: if (accept) cnt <= cnt + ONE_W;
        READOUT: if (rd_en) begin
          rd_addr <= rd_addr + ONE_A;
          rd_cnt  <= rd_cnt + ONE_W;
        end
        default: ;
      endcase
    end
  end

  // Buffer kept free of reset so it maps onto block RAM.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_addr] <= s_axis_tdata;
    if (rd_en) rd_q <= mem[rd_addr];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_q_valid <= 1'b0;
      rd_q_last  <= 1'b0;
    end else begin
      rd_q_valid <= rd_en;
      if (rd_en) rd_q_last <= ((rd_cnt + ONE_W) == tot);
    end
  end

  // Skid always holds the older item, so it drains into the output register first.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || m_axis_tready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        out_last   <= skid_last;
        skid_valid <= rd_q_valid;
        if (rd_q_valid) begin
          skid_data <= rd_q;
          skid_last <= rd_q_last;
        end
      end else if (rd_q_valid) begin
        out_valid <= 1'b1;
        out_data  <= rd_q;
        out_last  <= rd_q_last;
      end else begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end else if (rd_q_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= rd_q;
      skid_last  <= rd_q_last;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) sts_state <= 3'd0;
    else          sts_state <= state;
  end

  assign sts_trg_addr  = trg_addr;
  assign m_axis_tdata  = out_data;
  assign m_axis_tvalid = out_valid;
  assign m_axis_tlast  = out_valid && out_last;

endmodule
